// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - shared Wishbone bus widths and RAM slave state encoding
package wishbone_pkg;

   localparam int WB_ADDR_W = 16;
   localparam int WB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK,
      INIT
   } wb_slv_state_t;

endpackage

// File: rtl/wb_sp_ram.sv
// rtl/wb_sp_ram.sv - single-port synchronous RAM, registered read, write-first
module wb_sp_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/wishbone_ram_slave.sv
// rtl/wishbone_ram_slave.sv - pipelined Wishbone responder in front of the board-state RAM
// Optional power-up RAM clear when WB_RAM_CLEAR_EN is defined.
module wishbone_ram_slave
   import wishbone_pkg::*;
#(
   parameter int ADDR_W      = WB_ADDR_W,
   parameter int DATA_W      = WB_DATA_W,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [DATA_W-1:0] dat_i,
   output logic [DATA_W-1:0] dat_o,
   output logic              ack_o,
   output logic              stall_o
);

   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit PIPE   = (WAIT_CYCLES == 0);

`ifdef WB_RAM_CLEAR_EN
   localparam wb_slv_state_t RST_STATE = INIT;
`else
   localparam wb_slv_state_t RST_STATE = IDLE;
`endif

   wb_slv_state_t     state, state_nxt;
   logic [3:0]        wait_cnt;
   logic [RAM_AW-1:0] init_cnt;
   logic [RAM_AW-1:0] lat_adr;
   logic [DATA_W-1:0] lat_dat;
   logic              lat_we, lat_ok;
   logic              zero_q;
   logic [DATA_W-1:0] dat_hold;
   logic              idle, accept, adr_ok;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign idle    = (state == IDLE);
   assign stall_o = ~idle;
   assign accept  = cyc_i & stb_i & idle;
   assign adr_ok  = ({1'b0, adr_i} < (ADDR_W+1)'(DEPTH));
   // Out-of-range reads answer zero; otherwise dat_o is frozen between acks.
   assign dat_o   = ack_o ? (zero_q ? '0 : ram_rdata) : dat_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RST_STATE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && !PIPE) state_nxt = WAIT;
         WAIT: begin
            if (!cyc_i)               state_nxt = IDLE;
            else if (wait_cnt == 4'd1) state_nxt = ACK;
         end
         ACK:  state_nxt = IDLE;
         INIT: if (init_cnt == RAM_AW'(DEPTH - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = adr_i[RAM_AW-1:0];
      ram_wdata = dat_i;
      case (state)
         IDLE: ram_we = PIPE && accept && we_i && adr_ok;
         ACK: begin
            // A dropped cycle in ACK must not commit the latched write.
            ram_we    = lat_we && lat_ok && cyc_i;
            ram_addr  = lat_adr;
            ram_wdata = lat_dat;
         end
         INIT: begin
            ram_we    = 1'b1;
            ram_addr  = init_cnt;
            ram_wdata = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         init_cnt <= '0;
         lat_adr  <= '0;
         lat_dat  <= '0;
         lat_we   <= 1'b0;
         lat_ok   <= 1'b0;
         ack_o    <= 1'b0;
         zero_q   <= 1'b0;
         dat_hold <= '0;
      end else begin
         dat_hold <= dat_o;
         ack_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && PIPE) begin
                  ack_o  <= 1'b1;
                  zero_q <= ~adr_ok;
               end else if (accept) begin
                  wait_cnt <= 4'(WAIT_CYCLES);
                  lat_adr  <= adr_i[RAM_AW-1:0];
                  lat_dat  <= dat_i;
                  lat_we   <= we_i;
                  lat_ok   <= adr_ok;
               end
            end
            WAIT: wait_cnt <= wait_cnt - 4'd1;
            ACK: begin
               if (cyc_i) begin
                  ack_o  <= 1'b1;
                  zero_q <= ~lat_ok;
               end
            end
            INIT: init_cnt <= init_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   wb_sp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// tb/tb_wishbone_ram_slave.sv - directed self-checking bench for wishbone_ram_slave
module tb_wishbone_ram_slave;

   localparam int DEPTH = 16;
`ifdef WB_RAM_CLEAR_EN
   localparam logic [31:0] RST_STALL = 1;
   localparam logic [31:0] CLR_TICKS = DEPTH;
   localparam logic [31:0] EXP_AT0   = 'h00;
   localparam logic [31:0] EXP_AT15  = 'h00;
`else
   localparam logic [31:0] RST_STALL = 0;
   localparam logic [31:0] CLR_TICKS = 0;
   localparam logic [31:0] EXP_AT0   = 'h01;
   localparam logic [31:0] EXP_AT15  = 'hEE;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       cyc0 = 0, stb0 = 0, we0 = 0, ack0, stall0;
   logic [7:0] adr0 = 0, dat0i = 0, dat0o;
   logic       cyc3 = 0, stb3 = 0, we3 = 0, ack3, stall3;
   logic [7:0] adr3 = 0, dat3i = 0, dat3o;

   int n_cmp = 0;
   int n_bad = 0;

   wishbone_ram_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we0), .adr_i(adr0),
      .dat_i(dat0i), .dat_o(dat0o), .ack_o(ack0), .stall_o(stall0));

   wishbone_ram_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .cyc_i(cyc3), .stb_i(stb3), .we_i(we3), .adr_i(adr3),
      .dat_i(dat3i), .dat_o(dat3o), .ack_o(ack3), .stall_o(stall3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd0(input string tag, input logic [7:0] a, input logic [31:0] exp);
      cyc0 = 1; stb0 = 1; we0 = 0; adr0 = a;
      tick();
      cyc0 = 0; stb0 = 0;
      check({tag, "_ack"}, 32'(ack0), 1);
      check({tag, "_dat"}, 32'(dat0o), exp);
      tick();
   endtask

   // One transaction on the 3-wait-state slave; checks ack latency after the accept edge.
   task automatic xact3(input string tag, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] q);
      int n;
      cyc3 = 1; stb3 = 1; we3 = w; adr3 = a; dat3i = d;
      tick();
      stb3 = 0;
      n = 0;
      while (!ack3 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 32'(n), 4);
      q = dat3o;
      cyc3 = 0;
      tick();
   endtask

   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (stall3 && n < 200) begin
         tick();
         n++;
      end
      check(tag, 32'(n), CLR_TICKS);
      check({tag, "_s0"}, 32'(stall0), 0);
   endtask

   initial begin
      logic [7:0] q;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack0), 0);
      check("rst_dat", 32'(dat0o), 0);
      check("rst_stall", 32'(stall0), RST_STALL);
      check("rst_stall3", 32'(stall3), RST_STALL);
      rst = 0;
      wait_init("init_stall");

      // Write then read-after-write on consecutive cycles, zero wait states.
      cyc0 = 1; stb0 = 1; we0 = 1; adr0 = 3; dat0i = 8'h5A;
      check("raw_stall_pre", 32'(stall0), 0);
      tick();
      we0 = 0;
      check("raw_ack1", 32'(ack0), 1);
      check("raw_stall1", 32'(stall0), 0);
      tick();
      cyc0 = 0; stb0 = 0;
      check("raw_ack2", 32'(ack0), 1);
      check("raw_dat", 32'(dat0o), 'h5A);
      tick();
      check("raw_ack_off", 32'(ack0), 0);
      check("raw_hold", 32'(dat0o), 'h5A);

      // Preload @0..7 with i+1, then eight back-to-back reads.
      cyc0 = 1; stb0 = 1; we0 = 1;
      for (int i = 0; i < 8; i++) begin
         adr0 = 8'(i); dat0i = 8'(i + 1);
         tick();
      end
      we0 = 0;
      for (int i = 0; i < 8; i++) begin
         adr0 = 8'(i);
         tick();
         check("b2b_ack", 32'(ack0), 1);
         check("b2b_dat", 32'(dat0o), 32'(i + 1));
      end
      cyc0 = 0; stb0 = 0;
      tick();
      check("b2b_ack_off", 32'(ack0), 0);

      // Out-of-range write then read at DEPTH.
      cyc0 = 1; stb0 = 1; we0 = 1; adr0 = 8'(DEPTH); dat0i = 8'hFF;
      tick();
      we0 = 0;
      check("oor_wr_ack", 32'(ack0), 1);
      tick();
      cyc0 = 0; stb0 = 0;
      check("oor_rd_ack", 32'(ack0), 1);
      check("oor_rd_dat", 32'(dat0o), 0);
      tick();
      rd0("oor_ram0", 8'd0, 'h01);

      cyc0 = 1; stb0 = 1; we0 = 1; adr0 = 15; dat0i = 8'hEE;
      tick();
      cyc0 = 0; stb0 = 0;
      tick();
      rd0("top_word", 8'd15, 'hEE);

      // Three wait states: preload, then read @10 with a second request held on the bus.
      xact3("pre10", 1'b1, 8'd10, 8'h21, q);
      xact3("pre5", 1'b1, 8'd5, 8'h42, q);
      cyc3 = 1; stb3 = 1; we3 = 0; adr3 = 10;
      tick();
      adr3 = 5;
      for (int i = 0; i < 4; i++) begin
         check("ws_stall", 32'(stall3), 1);
         check("ws_ack_low", 32'(ack3), 0);
         tick();
      end
      check("ws_ack", 32'(ack3), 1);
      check("ws_dat", 32'(dat3o), 'h21);
      check("ws_stall_ack", 32'(stall3), 0);
      tick();
      stb3 = 0;
      check("ws_second_acc", 32'(stall3), 1);
      check("ws_hold", 32'(dat3o), 'h21);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ws2_ack_low", 32'(ack3), 0);
      end
      tick();
      check("ws2_ack", 32'(ack3), 1);
      check("ws2_dat", 32'(dat3o), 'h42);
      cyc3 = 0;
      tick();
      check("ws2_ack_off", 32'(ack3), 0);

      xact3("oor3", 1'b0, 8'(DEPTH), 8'h00, q);
      check("oor3_dat", 32'(q), 0);

      // Abort a latched write while waiting.
      cyc3 = 1; stb3 = 1; we3 = 1; adr3 = 5; dat3i = 8'h77;
      tick();
      stb3 = 0;
      tick();
      cyc3 = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_no_ack", 32'(ack3), 0);
      end
      check("abort_idle", 32'(stall3), 0);
      xact3("abort_rd", 1'b0, 8'd5, 8'h00, q);
      check("abort_old", 32'(q), 'h42);

      // Reset in the middle of a wait-state request.
      cyc3 = 1; stb3 = 1; we3 = 1; adr3 = 2; dat3i = 8'h99;
      tick();
      stb3 = 0;
      tick();
      rst = 1;
      #1;
      check("mid_rst_stall", 32'(stall3), RST_STALL);
      check("mid_rst_ack", 32'(ack3), 0);
      check("mid_rst_dat", 32'(dat3o), 0);
      tick();
      rst = 0; cyc3 = 0;
      wait_init("reinit_stall");
      check("reinit_ack3", 32'(ack3), 0);
      rd0("post_rst0", 8'd0, EXP_AT0);
      rd0("post_rst15", 8'(DEPTH - 1), EXP_AT15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
